// File: rtl/la_uart_rx.sv
// la_uart_rx: UART receiver for the logic-analyzer host link.
// Deserialises the line into bytes, LSB first, and keeps each one in a
// one-entry buffer with a valid/ready handshake. Framing, overrun and parity
// errors are reported as one-cycle pulses.
// Optional feature macro: UART_RX_PARITY_EN. When it is defined, frames are
// 8E1. When it is undefined, frames are 8N1 and parity_err is tied low.
module la_uart_rx #(
   parameter int BIT_CLKS = 104,
   parameter int CNT_W    = $clog2(BIT_CLKS) + 1
) (
   input  logic       clk,
   input  logic       rst_l,
   input  logic       uart_REC_dataH,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun_err,
   output logic       parity_err
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
`ifdef UART_RX_PARITY_EN
      , ST_PARITY
`endif
   } state_e;

   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(BIT_CLKS / 2);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CLKS - 1);

   // Synchroniser and receive state
   logic             sync1_q;
   logic             sync2_q;
   logic             line_s;
   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shift_q;
`ifdef UART_RX_PARITY_EN
   logic             par_q;
`endif

   // Output buffer and error pulses
   logic [7:0]       rx_data_q,     rx_data_d;
   logic             rx_valid_q,    rx_valid_d;
   logic             frame_err_q,   frame_err_d;
   logic             overrun_err_q, overrun_err_d;
   logic             parity_err_q,  parity_err_d;

   logic             half_tick;
   logic             bit_tick;
   logic             stop_sample;

   assign line_s      = sync2_q;
   assign half_tick   = (cnt_q == HALF_CNT);
   assign bit_tick    = (cnt_q == LAST_CNT);
   assign stop_sample = (state_q == ST_STOP) && bit_tick;

   // Two-flop synchroniser. It resets to the idle-high line level.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= uart_REC_dataH;
         sync2_q <= sync1_q;
      end
   end

   // Frame FSM: bit timing, start validation, data shift and stop handling.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_q     <= '0;
               bit_idx_q <= '0;
               if (!line_s) state_q <= ST_START;
            end
            ST_START: begin
               // Re-check the line at mid start bit so a short low glitch is ignored
               if (half_tick) begin
                  cnt_q   <= '0;
                  state_q <= line_s ? ST_IDLE : ST_DATA;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_DATA: begin
               if (bit_tick) begin
                  cnt_q     <= '0;
                  shift_q   <= {line_s, shift_q[7:1]};
                  bit_idx_q <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= ST_PARITY;
`else
                     state_q <= ST_STOP;
`endif
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (bit_tick) begin
                  cnt_q   <= '0;
                  par_q   <= line_s;
                  state_q <= ST_STOP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
`endif
            ST_STOP: begin
               // A low stop bit means a framing error. Hold off until the line
               // returns high so that a break is not taken as a new start bit.
               if (bit_tick) begin
                  cnt_q   <= '0;
                  state_q <= line_s ? ST_IDLE : ST_BREAK;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_BREAK: begin
               cnt_q <= '0;
               if (line_s) state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // Next state of the holding buffer and the error pulses at the stop-bit sample.
   always_comb begin
      rx_data_d     = rx_data_q;
      rx_valid_d    = rx_valid_q && !rx_ready;
      frame_err_d   = 1'b0;
      overrun_err_d = 1'b0;
      parity_err_d  = 1'b0;
      if (stop_sample) begin
         if (!line_s) begin
            frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
         end else if ((^shift_q) != par_q) begin
            // Drop the byte. The handshake still clears the buffer as usual.
            parity_err_d = 1'b1;
`endif
         end else if (rx_valid_q && !rx_ready) begin
            overrun_err_d = 1'b1;
         end else begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
         end
      end
   end

   // Holding buffer and error pulse registers.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         rx_data_q     <= 8'h00;
         rx_valid_q    <= 1'b0;
         frame_err_q   <= 1'b0;
         overrun_err_q <= 1'b0;
         parity_err_q  <= 1'b0;
      end else begin
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         frame_err_q   <= frame_err_d;
         overrun_err_q <= overrun_err_d;
         parity_err_q  <= parity_err_d;
      end
   end

   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign frame_err   = frame_err_q;
   assign overrun_err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err  = parity_err_q;
`else
   assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_la_uart_rx.sv
// Directed testbench for la_uart_rx with BIT_CLKS=16.
module tb_la_uart_rx;

   localparam int BC = 16;

   logic       clk = 1'b0;
   logic       rst_l;
   logic       line;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun_err;
   logic       parity_err;

   int n_checks = 0;
   int n_fail   = 0;

   // Event counters from the negedge monitor. The tests use differences of these counts.
   int         rise_cnt = 0;
   int         valid_cycles = 0;
   int         frame_cnt = 0;
   int         overrun_cnt = 0;
   int         parity_cnt = 0;
   logic [7:0] last_byte = 8'h00;
   logic       valid_prev = 1'b0;

   la_uart_rx #(.BIT_CLKS(BC)) dut (
      .clk            (clk),
      .rst_l          (rst_l),
      .uart_REC_dataH (line),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_ready       (rx_ready),
      .frame_err      (frame_err),
      .overrun_err    (overrun_err),
      .parity_err     (parity_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_valid && !valid_prev) begin
         rise_cnt  = rise_cnt + 1;
         last_byte = rx_data;
      end
      if (rx_valid)    valid_cycles = valid_cycles + 1;
      if (frame_err)   frame_cnt    = frame_cnt + 1;
      if (overrun_err) overrun_cnt  = overrun_cnt + 1;
      if (parity_err)  parity_cnt   = parity_cnt + 1;
      valid_prev = rx_valid;
   end

   task automatic hold(input logic v, input int n);
      line = v;
      repeat (n) @(negedge clk);
   endtask

   // Sends one frame. Under the parity build it adds the correct even-parity bit.
   task automatic send_frame(input logic [7:0] d, input logic stop_b);
      hold(1'b0, BC);
      for (int i = 0; i < 8; i++) hold(d[i], BC);
`ifdef UART_RX_PARITY_EN
      hold(^d, BC);
`endif
      hold(stop_b, BC);
      line = 1'b1;
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic send_frame_par(input logic [7:0] d, input logic par_b);
      hold(1'b0, BC);
      for (int i = 0; i < 8; i++) hold(d[i], BC);
      hold(par_b, BC);
      hold(1'b1, BC);
   endtask
`endif

   task automatic test_reset;
      n_checks++; if (rx_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_valid got %b exp 0", rx_valid); end
      n_checks++; if (rx_data !== 8'h00)    begin n_fail++; $display("FAIL reset_data got %h exp 00", rx_data); end
      n_checks++; if (frame_err !== 1'b0)   begin n_fail++; $display("FAIL reset_frame got %b exp 0", frame_err); end
      n_checks++; if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b exp 0", overrun_err); end
      n_checks++; if (parity_err !== 1'b0)  begin n_fail++; $display("FAIL reset_parity got %b exp 0", parity_err); end
      rst_l = 1'b1;
      hold(1'b1, 20);
   endtask

   task automatic test_basic_rx;
      int r0, v0, f0, o0, p0;
      r0 = rise_cnt; v0 = valid_cycles; f0 = frame_cnt; o0 = overrun_cnt; p0 = parity_cnt;
      rx_ready = 1'b1;
      send_frame(8'hA5, 1'b1);
      hold(1'b1, 20);
      n_checks++; if (rise_cnt - r0 !== 1)      begin n_fail++; $display("FAIL basic_rise got %0d exp 1", rise_cnt - r0); end
      n_checks++; if (valid_cycles - v0 !== 1)  begin n_fail++; $display("FAIL basic_valid_len got %0d exp 1", valid_cycles - v0); end
      n_checks++; if (last_byte !== 8'hA5)      begin n_fail++; $display("FAIL basic_byte got %h exp a5", last_byte); end
      n_checks++; if (rx_data !== 8'hA5)        begin n_fail++; $display("FAIL basic_data_kept got %h exp a5", rx_data); end
      n_checks++; if (frame_cnt - f0 !== 0)     begin n_fail++; $display("FAIL basic_frame got %0d exp 0", frame_cnt - f0); end
      n_checks++; if (overrun_cnt - o0 !== 0)   begin n_fail++; $display("FAIL basic_overrun got %0d exp 0", overrun_cnt - o0); end
      n_checks++; if (parity_cnt - p0 !== 0)    begin n_fail++; $display("FAIL basic_parity got %0d exp 0", parity_cnt - p0); end
   endtask

   task automatic test_overrun;
      int r0, o0;
      r0 = rise_cnt; o0 = overrun_cnt;
      rx_ready = 1'b0;
      send_frame(8'h3C, 1'b1);
      send_frame(8'hC3, 1'b1);
      hold(1'b1, 20);
      n_checks++; if (overrun_cnt - o0 !== 1) begin n_fail++; $display("FAIL ovr_count got %0d exp 1", overrun_cnt - o0); end
      n_checks++; if (rise_cnt - r0 !== 1)    begin n_fail++; $display("FAIL ovr_rise got %0d exp 1", rise_cnt - r0); end
      n_checks++; if (rx_valid !== 1'b1)      begin n_fail++; $display("FAIL ovr_valid_held got %b exp 1", rx_valid); end
      n_checks++; if (rx_data !== 8'h3C)      begin n_fail++; $display("FAIL ovr_data got %h exp 3c", rx_data); end
      rx_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (rx_valid !== 1'b0)      begin n_fail++; $display("FAIL ovr_clear got %b exp 0", rx_valid); end
      n_checks++; if (rx_data !== 8'h3C)      begin n_fail++; $display("FAIL ovr_data_after got %h exp 3c", rx_data); end
      hold(1'b1, 10);
   endtask

   task automatic test_frame_err;
      int r0, f0;
      r0 = rise_cnt; f0 = frame_cnt;
      rx_ready = 1'b1;
      hold(1'b0, BC);
      for (int i = 0; i < 8; i++) hold(i[0] ? 1'b0 : 1'b1, BC);
`ifdef UART_RX_PARITY_EN
      hold(1'b0, BC);
`endif
      hold(1'b0, 40);
      hold(1'b1, 32);
      n_checks++; if (frame_cnt - f0 !== 1) begin n_fail++; $display("FAIL frm_count got %0d exp 1", frame_cnt - f0); end
      n_checks++; if (rise_cnt - r0 !== 0)  begin n_fail++; $display("FAIL frm_no_valid got %0d exp 0", rise_cnt - r0); end
      send_frame(8'h0F, 1'b1);
      hold(1'b1, 20);
      n_checks++; if (rise_cnt - r0 !== 1)  begin n_fail++; $display("FAIL frm_next_rise got %0d exp 1", rise_cnt - r0); end
      n_checks++; if (last_byte !== 8'h0F)  begin n_fail++; $display("FAIL frm_next_byte got %h exp 0f", last_byte); end
      n_checks++; if (frame_cnt - f0 !== 1) begin n_fail++; $display("FAIL frm_no_extra got %0d exp 1", frame_cnt - f0); end
   endtask

   task automatic test_glitch;
      int r0, f0, o0, p0;
      r0 = rise_cnt; f0 = frame_cnt; o0 = overrun_cnt; p0 = parity_cnt;
      hold(1'b1, 20);
      hold(1'b0, 5);
      hold(1'b1, 200);
      n_checks++; if (rise_cnt - r0 !== 0) begin n_fail++; $display("FAIL glt_valid got %0d exp 0", rise_cnt - r0); end
      n_checks++; if ((frame_cnt - f0) + (overrun_cnt - o0) + (parity_cnt - p0) !== 0)
         begin n_fail++; $display("FAIL glt_errors got %0d exp 0", (frame_cnt - f0) + (overrun_cnt - o0) + (parity_cnt - p0)); end
      send_frame(8'h5A, 1'b1);
      hold(1'b1, 20);
      n_checks++; if (last_byte !== 8'h5A) begin n_fail++; $display("FAIL glt_after_byte got %h exp 5a", last_byte); end
   endtask

   task automatic test_reset_midframe;
      int r0, f0;
      hold(1'b0, BC);
      for (int i = 0; i < 4; i++) hold(1'b1, BC);
      hold(1'b1, 8);
      r0 = rise_cnt; f0 = frame_cnt;
      rst_l = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %b exp 0", rx_valid); end
      n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_data got %h exp 00", rx_data); end
      n_checks++; if ({frame_err, overrun_err, parity_err} !== 3'b000)
         begin n_fail++; $display("FAIL rst_mid_errs got %b exp 000", {frame_err, overrun_err, parity_err}); end
      rst_l = 1'b1;
      hold(1'b1, 64);
      send_frame(8'h81, 1'b1);
      hold(1'b1, 20);
      n_checks++; if (rise_cnt - r0 !== 1)  begin n_fail++; $display("FAIL rst_mid_rise got %0d exp 1", rise_cnt - r0); end
      n_checks++; if (last_byte !== 8'h81)  begin n_fail++; $display("FAIL rst_mid_byte got %h exp 81", last_byte); end
      n_checks++; if (frame_cnt - f0 !== 0) begin n_fail++; $display("FAIL rst_mid_frame got %0d exp 0", frame_cnt - f0); end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity;
      int r0, p0;
      r0 = rise_cnt; p0 = parity_cnt;
      rx_ready = 1'b1;
      send_frame_par(8'h07, 1'b1);
      hold(1'b1, 20);
      n_checks++; if (rise_cnt - r0 !== 1)   begin n_fail++; $display("FAIL par_ok_rise got %0d exp 1", rise_cnt - r0); end
      n_checks++; if (last_byte !== 8'h07)   begin n_fail++; $display("FAIL par_ok_byte got %h exp 07", last_byte); end
      n_checks++; if (parity_cnt - p0 !== 0) begin n_fail++; $display("FAIL par_ok_err got %0d exp 0", parity_cnt - p0); end
      send_frame_par(8'h07, 1'b0);
      hold(1'b1, 20);
      n_checks++; if (parity_cnt - p0 !== 1) begin n_fail++; $display("FAIL par_bad_err got %0d exp 1", parity_cnt - p0); end
      n_checks++; if (rise_cnt - r0 !== 1)   begin n_fail++; $display("FAIL par_bad_rise got %0d exp 1", rise_cnt - r0); end
      n_checks++; if (rx_valid !== 1'b0)     begin n_fail++; $display("FAIL par_bad_valid got %b exp 0", rx_valid); end
   endtask
`endif

   initial begin
      rst_l    = 1'b0;
      line     = 1'b1;
      rx_ready = 1'b1;
      repeat (3) @(negedge clk);
      test_reset;
      test_basic_rx;
      test_overrun;
      test_frame_err;
      test_glitch;
      test_reset_midframe;
`ifdef UART_RX_PARITY_EN
      test_parity;
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
